tc_dot_sequencer: RTL and testbench

- Initiator/collector on the other side of the tensor-core dot-product unit's valid/ready interface.
- Accepts one warp-level tensor request carrying NUM_THREAD independent dot-product jobs, each DIM_N-wide, plus one bias per job.
- Issues the jobs to the dot-product unit one per handshake, in lane order.
- Collects the in-order results into a single writeback vector with OR-merged exception flags.

---
 rtl/tc_dot_sequencer_pkg.sv | 35 +++
 rtl/tc_result_collector.sv | 49 ++++
 rtl/tc_dot_sequencer.sv | 146 ++++++++++++++
 tb/tb_tc_dot_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_dot_sequencer_pkg.sv
// Shared definitions for the tensor-core dot-product sequencer: FSM encoding,
// exception-flag layout and lane-slice index helpers.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

package tc_dot_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StOut
  } tc_state_e;

  // Exception flag bit positions within a 5-bit fflags vector.
  localparam int unsigned FflagsW = 5;
  localparam int unsigned FflagNv = 4;
  localparam int unsigned FflagDz = 3;
  localparam int unsigned FflagOf = 2;
  localparam int unsigned FflagUf = 1;
  localparam int unsigned FflagNx = 0;

  function automatic int unsigned tc_width(int unsigned expwidth, int unsigned precision);
    return expwidth + precision;
  endfunction

  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
    return lane * width;
  endfunction

  function automatic int unsigned lane_msb(int unsigned lane, int unsigned width);
    return (lane + 1) * width - 1;
  endfunction

endpackage

// File: rtl/tc_result_collector.sv
// Gathers in-order dot-product results into a lane vector and OR-accumulates
// their exception flags; flags the collect of the final lane.
module tc_result_collector
  import tc_dot_sequencer_pkg::*;
#(
  parameter int unsigned NUM_THREAD = 4,
  parameter int unsigned W          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    fire_i,
  input  logic [W-1:0]            result_i,
  input  logic [FflagsW-1:0]      fflags_i,
  output logic [NUM_THREAD*W-1:0] data_o,
  output logic [FflagsW-1:0]      fflags_o,
  output logic                    last_o
);

  localparam int unsigned CntW  = $clog2(NUM_THREAD) + 1;
  localparam int unsigned LaneW = $clog2(NUM_THREAD);

  logic [CntW-1:0]         col_cnt_q;
  logic [NUM_THREAD*W-1:0] data_q;
  logic [FflagsW-1:0]      fflags_q;
  logic [LaneW-1:0]        col_idx;

  assign col_idx  = col_cnt_q[LaneW-1:0];
  assign last_o   = fire_i && (col_cnt_q == CntW'(NUM_THREAD - 1));
  assign data_o   = data_q;
  assign fflags_o = fflags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q <= '0;
      data_q    <= '0;
      fflags_q  <= '0;
    end else if (clear_i) begin
      col_cnt_q <= '0;
      fflags_q  <= '0;
    end else if (fire_i) begin
      // Lane position comes only from arrival order; the dot unit is in-order.
      data_q[lane_lsb(32'(col_idx), W) +: W] <= result_i;
      fflags_q  <= fflags_q | fflags_i;
      col_cnt_q <= col_cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/tc_dot_sequencer.sv
// Issues a warp's NUM_THREAD dot-product jobs to the dot unit one lane at a
// time and returns the collected results as a single writeback.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

module tc_dot_sequencer
  import tc_dot_sequencer_pkg::*;
#(
  parameter int unsigned DIM_N      = 2,
  parameter int unsigned EXPWIDTH   = 8,
  parameter int unsigned PRECISION  = 24,
  parameter int unsigned NUM_THREAD = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             req_valid_i,
  output logic                                             req_ready_o,
  input  logic [NUM_THREAD*DIM_N*(EXPWIDTH+PRECISION)-1:0] req_a_i,
  input  logic [NUM_THREAD*DIM_N*(EXPWIDTH+PRECISION)-1:0] req_b_i,
  input  logic [NUM_THREAD*(EXPWIDTH+PRECISION)-1:0]       req_c_i,
  input  logic [2:0]                                       req_rm_i,
  input  logic [7:0]                                       req_reg_idxw_i,
  input  logic [`DEPTH_WARP-1:0]                           req_warpid_i,
  output logic                                             dp_in_valid_o,
  input  logic                                             dp_in_ready_i,
  output logic [DIM_N*(EXPWIDTH+PRECISION)-1:0]            dp_a_o,
  output logic [DIM_N*(EXPWIDTH+PRECISION)-1:0]            dp_b_o,
  output logic [EXPWIDTH+PRECISION-1:0]                    dp_c_o,
  output logic [2:0]                                       dp_rm_o,
  output logic [7:0]                                       dp_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0]                           dp_warpid_o,
  input  logic                                             dp_out_valid_i,
  output logic                                             dp_out_ready_o,
  input  logic [EXPWIDTH+PRECISION-1:0]                    dp_result_i,
  input  logic [4:0]                                       dp_fflags_i,
  output logic                                             wb_valid_o,
  input  logic                                             wb_ready_i,
  output logic [NUM_THREAD*(EXPWIDTH+PRECISION)-1:0]       wb_data_o,
  output logic [4:0]                                       wb_fflags_o,
  output logic [7:0]                                       wb_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0]                           wb_warpid_o
);

  localparam int unsigned W        = tc_width(EXPWIDTH, PRECISION);
  localparam int unsigned LaneBits = DIM_N * W;
  localparam int unsigned CntW     = $clog2(NUM_THREAD) + 1;
  localparam int unsigned LaneW    = $clog2(NUM_THREAD);

  tc_state_e state_q, state_d;
  logic [CntW-1:0] iss_cnt_q, iss_cnt_d;
  logic            latch;
  logic            issue_fire;
  logic            collect_fire;
  logic            collect_last;

  logic [NUM_THREAD-1:0][LaneBits-1:0] a_q, b_q;
  logic [NUM_THREAD-1:0][W-1:0]        c_q;
  logic [2:0]                          rm_q;
  logic [7:0]                          reg_idxw_q;
  logic [`DEPTH_WARP-1:0]              warpid_q;
  logic [LaneW-1:0]                    iss_idx;

  // Handshake outputs are decoded from registered state only.
  assign req_ready_o    = (state_q == StIdle);
  assign dp_in_valid_o  = (state_q == StRun) && (iss_cnt_q < CntW'(NUM_THREAD));
  assign dp_out_ready_o = (state_q == StRun);
  assign wb_valid_o     = (state_q == StOut);

  assign issue_fire   = dp_in_valid_o && dp_in_ready_i;
  assign collect_fire = dp_out_valid_i && dp_out_ready_o;

  // Low bits suffice: the slice is only consumed while iss_cnt_q < NUM_THREAD.
  assign iss_idx       = iss_cnt_q[LaneW-1:0];
  assign dp_a_o        = a_q[iss_idx];
  assign dp_b_o        = b_q[iss_idx];
  assign dp_c_o        = c_q[iss_idx];
  assign dp_rm_o       = rm_q;
  assign dp_reg_idxw_o = reg_idxw_q;
  assign dp_warpid_o   = warpid_q;
  assign wb_reg_idxw_o = reg_idxw_q;
  assign wb_warpid_o   = warpid_q;

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    latch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          latch     = 1'b1;
          iss_cnt_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (issue_fire) iss_cnt_d = iss_cnt_q + CntW'(1);
        if (collect_last) state_d = StOut;
      end
      StOut: begin
        if (wb_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      iss_cnt_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      rm_q       <= '0;
      reg_idxw_q <= '0;
      warpid_q   <= '0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      if (latch) begin
        a_q        <= req_a_i;
        b_q        <= req_b_i;
        c_q        <= req_c_i;
        rm_q       <= req_rm_i;
        reg_idxw_q <= req_reg_idxw_i;
        warpid_q   <= req_warpid_i;
      end
    end
  end

  tc_result_collector #(
    .NUM_THREAD (NUM_THREAD),
    .W          (W)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (latch),
    .fire_i   (collect_fire),
    .result_i (dp_result_i),
    .fflags_i (dp_fflags_i),
    .data_o   (wb_data_o),
    .fflags_o (wb_fflags_o),
    .last_o   (collect_last)
  );

endmodule

// File: tb/tb_tc_dot_sequencer.sv
// Bench for tc_dot_sequencer: an in-bench dot unit (4-cycle latency) and a
// transaction-level model checked against the DUT every cycle, plus literals.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

module tb_tc_dot_sequencer;

  localparam int DN = 2;
  localparam int NT = 4;
  localparam int W  = 32;
  localparam int WW = `DEPTH_WARP;
  localparam int LDP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 req_valid_i, req_ready_o;
  logic [NT*DN*W-1:0]   req_a_i, req_b_i;
  logic [NT*W-1:0]      req_c_i;
  logic [2:0]           req_rm_i;
  logic [7:0]           req_reg_idxw_i;
  logic [WW-1:0]        req_warpid_i;
  logic                 dp_in_valid_o, dp_in_ready_i;
  logic [DN*W-1:0]      dp_a_o, dp_b_o;
  logic [W-1:0]         dp_c_o;
  logic [2:0]           dp_rm_o;
  logic [7:0]           dp_reg_idxw_o;
  logic [WW-1:0]        dp_warpid_o;
  logic                 dp_out_valid_i, dp_out_ready_o;
  logic [W-1:0]         dp_result_i;
  logic [4:0]           dp_fflags_i;
  logic                 wb_valid_o, wb_ready_i;
  logic [NT*W-1:0]      wb_data_o;
  logic [4:0]           wb_fflags_o;
  logic [7:0]           wb_reg_idxw_o;
  logic [WW-1:0]        wb_warpid_o;

  tc_dot_sequencer #(
    .DIM_N      (DN),
    .EXPWIDTH   (8),
    .PRECISION  (24),
    .NUM_THREAD (NT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_a_i        (req_a_i),
    .req_b_i        (req_b_i),
    .req_c_i        (req_c_i),
    .req_rm_i       (req_rm_i),
    .req_reg_idxw_i (req_reg_idxw_i),
    .req_warpid_i   (req_warpid_i),
    .dp_in_valid_o  (dp_in_valid_o),
    .dp_in_ready_i  (dp_in_ready_i),
    .dp_a_o         (dp_a_o),
    .dp_b_o         (dp_b_o),
    .dp_c_o         (dp_c_o),
    .dp_rm_o        (dp_rm_o),
    .dp_reg_idxw_o  (dp_reg_idxw_o),
    .dp_warpid_o    (dp_warpid_o),
    .dp_out_valid_i (dp_out_valid_i),
    .dp_out_ready_o (dp_out_ready_o),
    .dp_result_i    (dp_result_i),
    .dp_fflags_i    (dp_fflags_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_data_o      (wb_data_o),
    .wb_fflags_o    (wb_fflags_o),
    .wb_reg_idxw_o  (wb_reg_idxw_o),
    .wb_warpid_o    (wb_warpid_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout expected event (t=%0t)", nm, $time);
  endtask

  // Single-precision <-> real, exact for the normal values used here.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    int e;
    if (x[30:0] == 31'd0) return 0.0;
    e = int'(x[30:23]) - 127 + 1023;
    d = {x[31], e[10:0], x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] dot_ref(input logic [DN*W-1:0] a, input logic [DN*W-1:0] b,
                                          input logic [W-1:0] c);
    real acc;
    acc = sp2r(c);
    for (int i = 0; i < DN; i++) acc += sp2r(a[i*W +: W]) * sp2r(b[i*W +: W]);
    return r2sp(acc);
  endfunction

  // Stimulus tables
  logic [31:0] ta[NT][DN];
  logic [31:0] tb[NT][DN];
  logic [31:0] tc[NT];
  logic [4:0]  tf[NT];
  logic [2:0]  trm;
  logic [7:0]  treg;
  logic [WW-1:0] twarp;

  // Model snapshot of the request in flight
  logic [DN*W-1:0] ma[NT];
  logic [DN*W-1:0] mb[NT];
  logic [31:0]     mc[NT];
  logic [4:0]      mf[NT];
  logic [31:0]     m_wb[NT];
  logic [4:0]      m_fl;
  logic [2:0]      m_rm;
  logic [7:0]      m_reg;
  logic [WW-1:0]   m_warp;
  bit m_busy = 0;
  bit m_wb_seen = 0;
  bit tog = 0;
  int m_iss = 0, m_col = 0, m_acc_edge = 0, m_done_edge = 0, m_lat = 0;
  int acc_cnt = 0, done_cnt = 0, dot_iss = 0;
  int edge_idx = -1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          due;
  } job_t;
  job_t dq[$];

  // Dot-unit environment and request-level model, advanced on each rising edge.
  initial begin
    job_t j;
    dp_in_ready_i  = 1'b1;
    dp_out_valid_i = 1'b0;
    dp_result_i    = '0;
    dp_fflags_i    = '0;
    forever begin
      @(posedge clk);
      edge_idx++;
      if (rst) begin
        m_busy = 0;
        dq.delete();
        dot_iss = 0;
      end else begin
        if (dp_out_valid_i && dp_out_ready_o) void'(dq.pop_front());
        if (dp_in_valid_o && dp_in_ready_i) begin
          j.res = dot_ref(dp_a_o, dp_b_o, dp_c_o);
          j.fl  = mf[dot_iss % NT];
          j.due = edge_idx + LDP;
          dq.push_back(j);
          dot_iss++;
        end
        if (!m_busy) begin
          if (req_valid_i) begin
            m_fl = '0;
            for (int k = 0; k < NT; k++) begin
              for (int i = 0; i < DN; i++) begin
                ma[k][i*W +: W] = ta[k][i];
                mb[k][i*W +: W] = tb[k][i];
              end
              mc[k]   = tc[k];
              mf[k]   = tf[k];
              m_fl   |= tf[k];
              m_wb[k] = dot_ref(ma[k], mb[k], mc[k]);
            end
            m_rm = trm; m_reg = treg; m_warp = twarp;
            m_busy = 1; m_iss = 0; m_col = 0; m_wb_seen = 0;
            m_acc_edge = edge_idx;
            dot_iss = 0;
            acc_cnt++;
          end
        end else if (m_col < NT) begin
          if (m_iss < NT && dp_in_ready_i) m_iss++;
          if (dp_out_valid_i) m_col++;
        end else if (wb_ready_i) begin
          m_busy = 0;
          m_done_edge = edge_idx;
          done_cnt++;
        end
      end
      #1;
      if (dq.size() > 0 && dq[0].due <= edge_idx + 1) begin
        dp_out_valid_i = 1'b1;
        dp_result_i    = dq[0].res;
        dp_fflags_i    = dq[0].fl;
      end else begin
        dp_out_valid_i = 1'b0;
        dp_result_i    = '0;
        dp_fflags_i    = '0;
      end
      dp_in_ready_i = tog ? ~dp_in_ready_i : 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    bit busy, e_in, e_wb;
    forever begin
      @(negedge clk);
      busy = m_busy && !rst;
      e_in = busy && m_col < NT && m_iss < NT;
      e_wb = busy && m_col == NT;
      chk("req_ready", 128'(req_ready_o), 128'(!busy));
      chk("dp_in_valid", 128'(dp_in_valid_o), 128'(e_in));
      chk("dp_out_ready", 128'(dp_out_ready_o), 128'(busy && m_col < NT));
      chk("wb_valid", 128'(wb_valid_o), 128'(e_wb));
      if (e_in) begin
        chk("dp_a", 128'(dp_a_o), 128'(ma[m_iss]));
        chk("dp_b", 128'(dp_b_o), 128'(mb[m_iss]));
        chk("dp_c", 128'(dp_c_o), 128'(mc[m_iss]));
        chk("dp_rm", 128'(dp_rm_o), 128'(m_rm));
        chk("dp_tags", 128'({dp_reg_idxw_o, dp_warpid_o}), 128'({m_reg, m_warp}));
      end
      if (e_wb) begin
        for (int k = 0; k < NT; k++) chk("wb_lane", 128'(wb_data_o[k*W +: W]), 128'(m_wb[k]));
        chk("wb_fflags", 128'(wb_fflags_o), 128'(m_fl));
        chk("wb_tags", 128'({wb_reg_idxw_o, wb_warpid_o}), 128'({m_reg, m_warp}));
        if (!m_wb_seen) begin
          m_wb_seen = 1;
          m_lat = edge_idx - m_acc_edge + 1;
        end
      end
    end
  end

  task automatic set_basic();
    for (int k = 0; k < NT; k++) begin
      ta[k][0] = 32'h3F800000; ta[k][1] = 32'h40000000;
      tb[k][0] = 32'h40000000; tb[k][1] = 32'h40000000;
      tc[k] = 32'h0;
      tf[k] = 5'h0;
    end
    trm = 3'd0; treg = 8'h11; twarp = WW'(1);
  endtask

  task automatic set_bias();
    logic [31:0] bias[NT];
    bias = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    for (int k = 0; k < NT; k++) tc[k] = bias[k];
  endtask

  task automatic load();
    for (int k = 0; k < NT; k++) begin
      for (int i = 0; i < DN; i++) begin
        req_a_i[(k*DN+i)*W +: W] = ta[k][i];
        req_b_i[(k*DN+i)*W +: W] = tb[k][i];
      end
      req_c_i[k*W +: W] = tc[k];
    end
    req_rm_i = trm; req_reg_idxw_i = treg; req_warpid_i = twarp;
  endtask

  task automatic wait_accept(input int n0);
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #2;
      if (acc_cnt != n0) begin
        req_valid_i = 1'b0;
        return;
      end
    end
    req_valid_i = 1'b0;
    bound_fail("accept");
  endtask

  task automatic send();
    int n0;
    load();
    n0 = acc_cnt;
    req_valid_i = 1'b1;
    wait_accept(n0);
  endtask

  task automatic wait_out();
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #2;
      if (m_busy && m_col == NT) begin
        @(negedge clk); #1;
        return;
      end
    end
    bound_fail("wb_valid");
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_cnt;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #2;
      if (done_cnt != n0) return;
    end
    bound_fail("wb_done");
  endtask

  task automatic chk_lanes(input logic [31:0] l0, l1, l2, l3);
    chk("lit_lane0", 128'(wb_data_o[0*W +: W]), 128'(l0));
    chk("lit_lane1", 128'(wb_data_o[1*W +: W]), 128'(l1));
    chk("lit_lane2", 128'(wb_data_o[2*W +: W]), 128'(l2));
    chk("lit_lane3", 128'(wb_data_o[3*W +: W]), 128'(l3));
  endtask

  initial begin
    int n0;
    req_valid_i = 1'b0;
    wb_ready_i  = 1'b1;
    set_basic();
    load();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", 128'(req_ready_o), 128'(1));
    chk("rst_dp_in_valid", 128'(dp_in_valid_o), 128'(0));
    chk("rst_dp_out_ready", 128'(dp_out_ready_o), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid_o), 128'(0));
    chk("rst_wb_data", 128'(wb_data_o), 128'(0));
    chk("rst_wb_fflags", 128'(wb_fflags_o), 128'(0));
    rst = 1'b0;
    @(posedge clk); #2;

    // 1: uniform lanes, 1*2 + 2*2 = 6.0, wb at cycle 9
    set_basic();
    send();
    wait_out();
    chk_lanes(32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000);
    chk("lit_fflags0", 128'(wb_fflags_o), 128'(0));
    chk("lit_latency", 128'(m_lat), 128'(9));
    wait_done();

    // 2: per-lane bias k*1.0
    set_basic(); set_bias();
    send();
    wait_out();
    chk_lanes(32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000);
    wait_done();

    // 3: issue backpressure toggling every cycle
    set_basic();
    tog = 1;
    send();
    wait_out();
    chk("lit_issue_count", 128'(dot_iss), 128'(4));
    chk_lanes(32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000);
    tog = 0;
    wait_done();

    // 4: flag accumulation and tag echo
    set_basic();
    tf[2] = 5'h01; tf[3] = 5'h04; treg = 8'h2A; twarp = WW'(3);
    send();
    wait_out();
    chk("lit_fflags5", 128'(wb_fflags_o), 128'(5'h05));
    chk("lit_reg", 128'(wb_reg_idxw_o), 128'(8'h2A));
    chk("lit_warp", 128'(wb_warpid_o), 128'(3));
    wait_done();

    // 5: writeback stall, then back-to-back request
    wb_ready_i = 1'b0;
    set_basic();
    send();
    wait_out();
    set_bias();
    load();
    req_valid_i = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #2;
      chk("stall_req_ready", 128'(req_ready_o), 128'(0));
      chk("stall_wb_valid", 128'(wb_valid_o), 128'(1));
      chk("stall_wb_data", 128'(wb_data_o), {4{32'h40C00000}});
    end
    n0 = acc_cnt;
    wb_ready_i = 1'b1;
    wait_accept(n0);
    chk("lit_b2b_gap", 128'(m_acc_edge - m_done_edge), 128'(1));
    wait_out();
    chk_lanes(32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000);
    wait_done();

    // 6: reset mid-issue, then a fresh request
    set_basic();
    send();
    for (int t = 0; t < 20 && m_iss != 2; t++) begin
      @(posedge clk); #2;
    end
    chk("pre_rst_iss", 128'(m_iss), 128'(2));
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("post_rst_req_ready", 128'(req_ready_o), 128'(1));
    chk("post_rst_wb_valid", 128'(wb_valid_o), 128'(0));
    set_bias();
    send();
    wait_out();
    chk_lanes(32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000);
    wait_done();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
